audio_spi_arbiter: RTL and testbench

Shares the audio codec's single SPI control port between two register-access requesters: port 0 for the power-up register-table loader and port 1 for runtime control such as volume and mute. Each request becomes one 16-bit SPI frame, either a write or a read. The block owns the physical pins oCS_n, oSCLK, oDIN and iDOUT. It arbitrates round-robin, generates SCLK from iCLK_50, and returns read data and a completion pulse to the requester it granted.

---
 rtl/audio_spi_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_audio_spi_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_spi_arbiter.sv
// audio_spi_arbiter
//   Shares the audio codec's single SPI control port between two register
//   requesters (port 0: power-up table loader, port 1: runtime control).
//   Each granted request becomes one 16-bit frame {addr[6:0], rw, data[7:0]},
//   shifted MSB first. Read frames send 8'hFF in the data field, and the last
//   8 bits sampled from iDOUT become the read result.
//
// Parameters
//   CLK_DIV : SCLK half-period in iCLK_50 cycles (2..255)
//   CS_GAP  : CS_n-high gap after a frame, in SCLK half-periods (1..15)
//
// Ports
//   iCLK_50, iRESET_n          : clock, synchronous active-low reset
//   iREQ0/1, iRW0/1            : request level and direction (1 = read)
//   iADDR0/1, iWDATA0/1        : register address and write data
//   oGNT0/1                    : grant, held from acceptance through oDONEx
//   oDONE0/1                   : one-cycle completion pulse
//   oRDATA0/1                  : last read result per port
//   oBUSY                      : any state other than IDLE
//   oCS_n, oSCLK, oDIN, iDOUT  : codec SPI pins
module audio_spi_arbiter #(
  parameter int CLK_DIV = 62,
  parameter int CS_GAP  = 2
) (
  input  logic       iCLK_50,
  input  logic       iRESET_n,
  input  logic       iREQ0,
  input  logic       iREQ1,
  input  logic       iRW0,
  input  logic       iRW1,
  input  logic [6:0] iADDR0,
  input  logic [6:0] iADDR1,
  input  logic [7:0] iWDATA0,
  input  logic [7:0] iWDATA1,
  output logic       oGNT0,
  output logic       oGNT1,
  output logic       oDONE0,
  output logic       oDONE1,
  output logic [7:0] oRDATA0,
  output logic [7:0] oRDATA1,
  output logic       oBUSY,
  output logic       oCS_n,
  output logic       oSCLK,
  output logic       oDIN,
  input  logic       iDOUT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Terminal counts for the SCLK divider and the post-frame CS_n gap.
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(CS_GAP * CLK_DIV - 1);

  logic [2:0]  state_r;
  logic [15:0] tx_r;
  logic [7:0]  rx_r;
  logic [7:0]  div_r;
  logic [4:0]  bit_r;
  logic [11:0] gap_r;
  logic        port_r;
  logic        rw_r;
  logic        last_r;

  logic        win_s;
  logic        win_rw_s;
  logic [15:0] frame_s;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    win_s = 1'b0;
    if (iREQ0 && iREQ1) begin
      win_s = ~last_r;
    end else if (iREQ1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Assemble the winner's frame; reads carry 8'hFF in the data field.
  always_comb begin
    win_rw_s = 1'b0;
    frame_s  = 16'h0000;
    if (win_s) begin
      win_rw_s = iRW1;
      frame_s  = {iADDR1, iRW1, (iRW1 ? 8'hFF : iWDATA1)};
    end else begin
      win_rw_s = iRW0;
      frame_s  = {iADDR0, iRW0, (iRW0 ? 8'hFF : iWDATA0)};
    end
  end

  // Transaction FSM, SCLK generation, shift registers and registered outputs.
  always_ff @(posedge iCLK_50) begin
    if (!iRESET_n) begin
      state_r <= ST_IDLE;
      tx_r    <= 16'h0000;
      rx_r    <= 8'h00;
      div_r   <= 8'h00;
      bit_r   <= 5'd0;
      gap_r   <= 12'd0;
      port_r  <= 1'b0;
      rw_r    <= 1'b0;
      last_r  <= 1'b1;  // so port 0 wins the first tie
      oGNT0   <= 1'b0;
      oGNT1   <= 1'b0;
      oDONE0  <= 1'b0;
      oDONE1  <= 1'b0;
      oRDATA0 <= 8'h00;
      oRDATA1 <= 8'h00;
      oBUSY   <= 1'b0;
      oCS_n   <= 1'b1;
      oSCLK   <= 1'b0;
      oDIN    <= 1'b0;
    end else begin
      oDONE0 <= 1'b0;
      oDONE1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iREQ0 || iREQ1) begin
            port_r  <= win_s;
            rw_r    <= win_rw_s;
            tx_r    <= frame_s;
            oGNT0   <= ~win_s;
            oGNT1   <= win_s;
            oBUSY   <= 1'b1;
            // CS_n and the first data bit go out together so the LOAD
            // cycle already presents bit 15 to the codec.
            oCS_n   <= 1'b0;
            oDIN    <= frame_s[15];
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          div_r   <= 8'h00;
          bit_r   <= 5'd0;
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_r == DIV_LAST) begin
            div_r <= 8'h00;
            oSCLK <= ~oSCLK;
            if (!oSCLK) begin
              // Rising edge: the codec's data is stable, capture it.
              rx_r <= {rx_r[6:0], iDOUT};
            end else begin
              // Falling edge: one bit done; advance data while SCLK is low.
              bit_r <= bit_r + 5'd1;
              if (bit_r == 5'd15) begin
                oCS_n   <= 1'b1;
                oDIN    <= 1'b0;
                gap_r   <= 12'd0;
                state_r <= ST_GAP;
              end else begin
                tx_r <= {tx_r[14:0], 1'b0};
                oDIN <= tx_r[14];
              end
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            state_r <= ST_DONE;
            if (port_r) begin
              oDONE1 <= 1'b1;
              if (rw_r) begin
                oRDATA1 <= rx_r;
              end else begin
                oRDATA1 <= oRDATA1;
              end
            end else begin
              oDONE0 <= 1'b1;
              if (rw_r) begin
                oRDATA0 <= rx_r;
              end else begin
                oRDATA0 <= oRDATA0;
              end
            end
          end else begin
            gap_r <= gap_r + 12'd1;
          end
        end
        ST_DONE: begin
          oGNT0   <= 1'b0;
          oGNT1   <= 1'b0;
          oBUSY   <= 1'b0;
          last_r  <= port_r;
          state_r <= ST_IDLE;
        end
        default: begin
          // Unreachable encoding: drop back to a safe, idle pin state.
          oGNT0   <= 1'b0;
          oGNT1   <= 1'b0;
          oBUSY   <= 1'b0;
          oCS_n   <= 1'b1;
          oSCLK   <= 1'b0;
          oDIN    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_spi_arbiter.sv
// Self-checking bench for audio_spi_arbiter. A transaction-level reference
// model predicts, for every clock edge, the grant/done/busy/pin values from
// the arbitration rule and the frame timing arithmetic; a small codec model
// answers reads on iDOUT. Directed scenarios are followed by random traffic.
module tb_audio_spi_arbiter;

  localparam int D = 4;
  localparam int G = 2;
  localparam int L = (32 + G) * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] f_addr [2];
  logic       f_rw   [2];
  logic [7:0] f_wd   [2];
  int         want   [2];
  logic       dout = 1'b1;

  logic       gnt0, gnt1, done0, done1, busy, cs_n, sclk, din;
  logic [7:0] rd0, rd1;
  logic       req0, req1;

  assign req0 = (want[0] > 0);
  assign req1 = (want[1] > 0);

  always #10 clk = ~clk;

  audio_spi_arbiter #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .iCLK_50(clk), .iRESET_n(rst_n),
    .iREQ0(req0), .iREQ1(req1), .iRW0(f_rw[0]), .iRW1(f_rw[1]),
    .iADDR0(f_addr[0]), .iADDR1(f_addr[1]),
    .iWDATA0(f_wd[0]), .iWDATA1(f_wd[1]),
    .oGNT0(gnt0), .oGNT1(gnt1), .oDONE0(done0), .oDONE1(done1),
    .oRDATA0(rd0), .oRDATA1(rd1), .oBUSY(busy),
    .oCS_n(cs_n), .oSCLK(sclk), .oDIN(din), .iDOUT(dout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  // reference model state
  bit          m_act = 1'b0;
  int          m_s = 0;
  int          m_free = 0;
  bit          m_port = 1'b0;
  bit          m_last = 1'b1;
  bit          m_rw = 1'b0;
  logic [15:0] m_frame = 16'h0;
  logic [15:0] m_resp = 16'h0;
  logic [7:0]  m_rd [2];
  bit          rnd_en = 1'b0;
  bit          resp_ovr = 1'b0;
  logic [15:0] resp_val = 16'h0;

  // codec / observation state
  int          codec_j = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_g0 = 1'b0;
  logic        prev_g1 = 1'b0;
  logic [15:0] cap = 16'h0;
  int          cap_n = 0;
  int          grant_log [$];
  int          done_cnt [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, k);
    end
  endtask

  // Advance one clock edge, update the model and compare every output.
  task automatic step();
    bit          s_rst;
    bit [1:0]    s_req;
    logic [6:0]  s_addr [2];
    logic        s_rw [2];
    logic [7:0]  s_wd [2];
    bit          granted [2];
    int          o;
    int          bi;
    logic        e_sclk, e_din, e_cs;
    s_rst = rst_n;
    s_req = {req1, req0};
    for (int p = 0; p < 2; p++) begin
      s_addr[p] = f_addr[p]; s_rw[p] = f_rw[p]; s_wd[p] = f_wd[p];
      granted[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    k++;
    if (!s_rst) begin
      m_act = 1'b0; m_free = k + 1; m_last = 1'b1;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    end else begin
      if (m_act && k == m_s + 1 + L && m_rw) m_rd[m_port] = m_resp[7:0];
      if (m_act && k == m_s + 2 + L) m_act = 1'b0;
      if (!m_act && k >= m_free && s_req != 2'b00) begin
        m_port  = (s_req == 2'b11) ? !m_last : s_req[1];
        m_last  = m_port;
        m_act   = 1'b1;
        m_s     = k;
        m_free  = k + 3 + L;
        m_rw    = s_rw[m_port];
        m_frame = {s_addr[m_port], s_rw[m_port], (s_rw[m_port] ? 8'hFF : s_wd[m_port])};
        m_resp  = resp_ovr ? resp_val : 16'($urandom);
        granted[m_port] = 1'b1;
        want[m_port]--;
      end
    end
    o = k - m_s;
    e_cs   = !(m_act && o <= 32 * D);
    e_sclk = m_act && o >= 1 + D && o < 1 + 32 * D && (((o - 1) / D) % 2 == 1);
    e_din  = 1'b0;
    if (m_act && o < 1 + 32 * D) begin
      bi = (o == 0) ? 15 : 15 - (o - 1) / (2 * D);
      e_din = m_frame[bi];
    end
    check_eq("gnt0",  gnt0,  m_act && !m_port);
    check_eq("gnt1",  gnt1,  m_act && m_port);
    check_eq("gnt_excl", gnt0 & gnt1, 1'b0);
    check_eq("done0", done0, m_act && !m_port && o == 1 + L);
    check_eq("done1", done1, m_act && m_port && o == 1 + L);
    check_eq("busy",  busy,  m_act);
    check_eq("cs_n",  cs_n,  e_cs);
    check_eq("sclk",  sclk,  e_sclk);
    check_eq("din",   din,   e_din);
    check_eq("rdata0", rd0, m_rd[0]);
    check_eq("rdata1", rd1, m_rd[1]);
    // observation of the bus: grant order, done counts, captured frame
    if (gnt0 && !prev_g0) grant_log.push_back(0);
    if (gnt1 && !prev_g1) grant_log.push_back(1);
    if (done0) done_cnt[0]++;
    if (done1) done_cnt[1]++;
    if (!prev_sclk && sclk) begin cap = {cap[14:0], din}; cap_n++; end
    if (prev_cs && !cs_n) cap_n = 0;
    if (!prev_cs && cs_n) begin
      if (cap_n == 16) check_eq("frame", cap, m_frame);
      cap_n = 0;
    end
    // codec: present bit j of its response after j falling SCLK edges
    if (cs_n) codec_j = 0;
    else if (prev_sclk && !sclk) codec_j++;
    dout = (cs_n || codec_j > 15) ? 1'b1 : m_resp[15 - codec_j];
    prev_sclk = sclk; prev_cs = cs_n; prev_g0 = gnt0; prev_g1 = gnt1;
    // random requesters
    if (rnd_en) begin
      for (int p = 0; p < 2; p++) begin
        if (granted[p] || want[p] == 0) begin
          f_addr[p] = 7'($urandom); f_rw[p] = 1'($urandom); f_wd[p] = 8'($urandom);
        end
        if (want[p] == 0 && $urandom_range(0, 15) == 0) want[p] = $urandom_range(1, 3);
      end
    end
  endtask

  // Run until the model is idle with no pending requests, bounded.
  task automatic drain(input string tag);
    int budget;
    budget = 6000;
    while ((m_act || want[0] > 0 || want[1] > 0 || k < m_free) && budget > 0) begin
      step();
      budget--;
    end
    check_eq({tag, "_timeout"}, (budget == 0), 1'b0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      f_addr[p] = 7'h00; f_rw[p] = 1'b0; f_wd[p] = 8'h00; want[p] = 0;
      m_rd[p] = 8'h00; done_cnt[p] = 0;
    end
    // Reset with requests pending; port 0 write, port 1 read.
    f_addr[0] = 7'h22; f_rw[0] = 1'b0; f_wd[0] = 8'h5A; want[0] = 1;
    f_addr[1] = 7'h0F; f_rw[1] = 1'b1; f_wd[1] = 8'h33; want[1] = 1;
    resp_ovr = 1'b1; resp_val = 16'h3CA5;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    drain("t_basic");
    check_eq("first_grant", grant_log.size() > 0 ? grant_log[0] : 9, 0);
    check_eq("rd0_kept", rd0, 8'h00);
    check_eq("rd1_a5", rd1, 8'hA5);
    resp_ovr = 1'b0;

    // Both ports hold requests for two transactions each.
    grant_log.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    f_rw[0] = 1'b0; f_wd[0] = 8'hC3; f_rw[1] = 1'b1;
    want[0] = 2; want[1] = 2;
    drain("t_tie");
    check_eq("tie_n", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("tie_order", grant_log[i], i % 2);
    check_eq("tie_done0", done_cnt[0], 2);
    check_eq("tie_done1", done_cnt[1], 2);

    // Port 1 alone, three back-to-back writes.
    f_rw[1] = 1'b0; f_addr[1] = 7'h11; f_wd[1] = 8'h7E;
    want[1] = 3;
    drain("t_b2b");

    // Reset in the middle of a port 0 write, around bit 8.
    f_rw[0] = 1'b0; f_addr[0] = 7'h55; f_wd[0] = 8'h96;
    want[0] = 1;
    begin
      int budget;
      budget = 400;
      while (!(m_act && k - m_s == 1 + 16 * D) && budget > 0) begin step(); budget--; end
      check_eq("midrst_reach", (budget == 0), 1'b0);
    end
    done_cnt[0] = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("midrst_cs", cs_n, 1'b1);
    check_eq("midrst_sclk", sclk, 1'b0);
    step();
    check_eq("midrst_nodone", done_cnt[0], 0);
    want[0] = 1;
    drain("t_after_rst");
    check_eq("after_rst_done", done_cnt[0], 1);

    // Random traffic on both ports.
    rnd_en = 1'b1;
    for (int i = 0; i < 8000; i++) step();
    rnd_en = 1'b0;
    drain("t_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
